uart_rx: RTL and testbench

UART receive path of the low-power multi-clock system, the counterpart of the UART transmit chain on the same serial link. It oversamples `rx_in` with a configurable prescale and detects the start bit. It then majority-samples each bit at mid-period, checks optional parity and the stop bit, and delivers the received byte with a one-cycle valid strobe. It sits in the UART clock domain between the pin-side synchronizer and the RX data synchronizer toward the system domain.

---
 rtl/uart_pkg.sv | 44 ++++
 rtl/uart_rx_sampler.sv | 54 +++++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg: constants and types shared by the UART receive and transmit paths.
//   - rx_state_e    : receive FSM state encoding
//   - PRESCALE_*    : legal oversampling ratios
//   - PAR_EVEN/ODD  : parity-type select values
//   - rx_cfg_t      : per-frame configuration latched at the start bit
//   - eff_prescale  : maps an illegal prescale onto the 8x default
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int unsigned PRESCALE_W = 6;

   localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
   localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
   localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

   typedef struct packed {
      logic [PRESCALE_W-1:0] prescale;
      logic                  par_en;
      logic                  par_typ;
   } rx_cfg_t;

   localparam rx_cfg_t RX_CFG_RST = '{prescale: PRESCALE_8, par_en: 1'b0, par_typ: PAR_EVEN};

   // Anything other than 8/16/32 behaves as 8.
   function automatic logic [PRESCALE_W-1:0] eff_prescale(input logic [PRESCALE_W-1:0] p);
      case (p)
         PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
         default:                              return PRESCALE_8;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler: per-bit edge counter and three-point majority sampler.
//   clk, rst           : UART clock, synchronous active-high reset
//   rx_i               : synchronized serial line
//   clr_i              : hold the edge counter at 0 (receiver idle)
//   prescale_i         : effective oversampling ratio P (8/16/32)
//   sample_valid_c_o   : edge P/2+2, majority bit is valid
//   bit_done_c_o       : edge P-1, last cycle of the bit period
//   bit_c_o            : majority of samples at edges P/2-1, P/2, P/2+1
// ---------------------------------------------------------------------------
module uart_rx_sampler
   import uart_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_i,
   input  logic                  clr_i,
   input  logic [PRESCALE_W-1:0] prescale_i,
   output logic                  sample_valid_c_o,
   output logic                  bit_done_c_o,
   output logic                  bit_c_o
);

   logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [2:0]            smp_q, smp_d;
   logic [PRESCALE_W-1:0] half_c;

   // Edge counting and sample capture around mid-bit.
   always_comb begin
      half_c           = prescale_i >> 1;
      bit_done_c_o     = (edge_cnt_q == prescale_i - PRESCALE_W'(1));
      sample_valid_c_o = (edge_cnt_q == half_c + PRESCALE_W'(2));
      bit_c_o          = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

      smp_d = smp_q;
      if (edge_cnt_q == half_c - PRESCALE_W'(1)) smp_d[0] = rx_i;
      if (edge_cnt_q == half_c)                  smp_d[1] = rx_i;
      if (edge_cnt_q == half_c + PRESCALE_W'(1)) smp_d[2] = rx_i;

      if (clr_i || bit_done_c_o) edge_cnt_d = '0;
      else                       edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         edge_cnt_q <= '0;
         smp_q      <= 3'b111;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         smp_q      <= smp_d;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx: UART receiver (start, DATA_WIDTH bits LSB first, optional parity,
// stop) with oversampling and majority voting.
//   clk, rst   : UART oversampling clock, synchronous active-high reset
//   rx_in      : synchronized serial line, idles high
//   prescale   : oversampling ratio (8/16/32, others act as 8)
//   par_en     : parity bit present
//   par_typ    : 0 even, 1 odd
//   p_data     : last correctly received byte
//   data_valid : one-cycle strobe, p_data new
//   par_err    : one-cycle strobe, parity mismatch
//   stop_err   : one-cycle strobe, stop bit sampled 0
// ---------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic [DATA_WIDTH-1:0] p_data,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stop_err
);

   localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   rx_state_e             state_q, state_d;
   rx_cfg_t               cfg_q, cfg_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic                  frame_perr_q, frame_perr_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  data_valid_q, data_valid_d;
   logic                  par_err_q, par_err_d;
   logic                  stop_err_q, stop_err_d;

   logic clr_c;
   logic sample_valid_c, bit_done_c, bit_c;

   uart_rx_sampler u_sampler (
      .clk              (clk),
      .rst              (rst),
      .rx_i             (rx_in),
      .clr_i            (clr_c),
      .prescale_i       (cfg_q.prescale),
      .sample_valid_c_o (sample_valid_c),
      .bit_done_c_o     (bit_done_c),
      .bit_c_o          (bit_c)
   );

   // Next-state, shift register, parity check and strobe generation.
   always_comb begin
      state_d      = state_q;
      cfg_d        = cfg_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      frame_perr_d = frame_perr_q;
      p_data_d     = p_data_q;
      data_valid_d = 1'b0;
      par_err_d    = 1'b0;
      stop_err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!rx_in) begin
               state_d      = ST_START;
               cfg_d        = '{prescale: eff_prescale(prescale), par_en: par_en, par_typ: par_typ};
               bit_cnt_d    = '0;
               frame_perr_d = 1'b0;
            end
         end
         ST_START: begin
            // A high majority means the low pulse was a glitch.
            if (bit_done_c) state_d = bit_c ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (sample_valid_c) shift_d = {bit_c, shift_q[DATA_WIDTH-1:1]};
            if (bit_done_c) begin
               if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = cfg_q.par_en ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (sample_valid_c) frame_perr_d = bit_c ^ (^shift_q) ^ (cfg_q.par_typ == PAR_ODD);
            if (bit_done_c)     state_d      = ST_STOP;
         end
         ST_STOP: begin
            // Leave at mid-stop so a back-to-back start edge is not missed.
            if (sample_valid_c) begin
               state_d = ST_IDLE;
               if (!frame_perr_q && bit_c) begin
                  data_valid_d = 1'b1;
                  p_data_d     = shift_q;
               end else begin
                  par_err_d  = frame_perr_q;
                  stop_err_d = !bit_c;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      clr_c = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cfg_q        <= RX_CFG_RST;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         frame_perr_q <= 1'b0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stop_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cfg_q        <= cfg_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         frame_perr_q <= frame_perr_d;
         p_data_q     <= p_data_d;
         data_valid_q <= data_valid_d;
         par_err_q    <= par_err_d;
         stop_err_q   <= stop_err_d;
      end
   end

   assign p_data     = p_data_q;
   assign data_valid = data_valid_q;
   assign par_err    = par_err_q;
   assign stop_err   = stop_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx: builds a per-cycle line/config/reset waveform, plays it into
// uart_rx and checks every cycle against a frame-level model that reads the
// recorded line history (majority of mid-bit samples at absolute times).
// ---------------------------------------------------------------------------
module tb_uart_rx;

   localparam int unsigned W    = 8;
   localparam int unsigned MAXC = 65536;

   logic         clk;
   logic         rst;
   logic         rx_in;
   logic [5:0]   prescale;
   logic         par_en;
   logic         par_typ;
   logic [W-1:0] p_data;
   logic         data_valid;
   logic         par_err;
   logic         stop_err;

   uart_rx #(.DATA_WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_in      (rx_in),
      .prescale   (prescale),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stop_err   (stop_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic       rx;
      logic [5:0] pre;
      logic       pe;
      logic       pt;
   } stim_t;

   typedef struct {
      int           cyc;
      logic         dv;
      logic         pe;
      logic         se;
      logic [W-1:0] pd;
      string        nm;
   } pin_t;

   stim_t stim_q[$];
   pin_t  pin_q[$];
   logic  line_h [MAXC];

   int tests = 0;
   int fails = 0;

   // Model state
   bit           busy;
   int           t0m, pm;
   bit           pem, ptm;
   logic         exp_dv, exp_pe, exp_se;
   logic [W-1:0] exp_pd;

   function automatic int peff(input logic [5:0] p);
      if (p == 6'd8 || p == 6'd16 || p == 6'd32) return int'(p);
      return 8;
   endfunction

   task automatic push(input logic r, input logic x, input logic [5:0] pre, input logic pe, input logic pt);
      stim_t s;
      s.rst = r; s.rx = x; s.pre = pre; s.pe = pe; s.pt = pt;
      stim_q.push_back(s);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) push(1'b0, 1'b1, 6'd8, 1'b0, 1'b0);
   endtask

   task automatic add_pin(input int cyc, input logic dv, input logic pe, input logic se,
                          input logic [W-1:0] pd, input string nm);
      pin_t p;
      p.cyc = cyc; p.dv = dv; p.pe = pe; p.se = se; p.pd = pd; p.nm = nm;
      pin_q.push_back(p);
   endtask

   // One frame; abort_at >= 0 replaces the frame from that cycle with 2 reset cycles.
   task automatic send_frame(input logic [W-1:0] d, input logic [5:0] pre, input logic pe,
                             input logic pt, input logic pflip, input logic stopb,
                             input logic scramble, input int abort_at, output int t0);
      logic bits [W+3];
      int   p, n, idx;
      p = peff(pre);
      n = 1 + int'(W) + int'(pe);
      bits[0] = 1'b0;
      for (int i = 0; i < int'(W); i++) bits[1+i] = d[i];
      if (pe) bits[W+1] = (^d) ^ pt ^ pflip;
      bits[n] = stopb;
      t0 = stim_q.size();
      for (int b = 0; b <= n; b++) begin
         for (int e = 0; e < p; e++) begin
            idx = b * p + e;
            if (abort_at >= 0 && idx == abort_at) begin
               push(1'b1, 1'b1, pre, pe, pt);
               push(1'b1, 1'b1, pre, pe, pt);
               return;
            end
            if (scramble && idx > 0)
               push(1'b0, bits[b], 6'($urandom), 1'($urandom), 1'($urandom));
            else
               push(1'b0, bits[b], pre, pe, pt);
         end
      end
   endtask

   function automatic logic maj(input int t0, input int p, input int b);
      int base, s;
      base = t0 + b * p + p / 2;
      s = int'(line_h[base-1]) + int'(line_h[base]) + int'(line_h[base+1]);
      return (s >= 2);
   endfunction

   task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
      end
   endtask

   initial begin
      int    t0, t1, t2, n;
      int    k, nb;
      stim_t s;
      logic  nd, np, ns, perr, stp;
      logic [W-1:0] npd, dbyte;
      logic [5:0] rp;

      rst = 1'b1; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;

      // ---------------- directed stimulus ----------------
      for (int i = 0; i < 3; i++) push(1'b1, 1'b1, 6'd8, 1'b0, 1'b0);
      idle(5);
      send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0);
      add_pin(t0 + 79, 1'b1, 1'b0, 1'b0, 8'hA5, "p8_a5");
      idle(10);
      send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0);
      add_pin(t0 + 171, 1'b1, 1'b0, 1'b0, 8'h3C, "p16_even_ok");
      idle(10);
      send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1, t0);
      add_pin(t0 + 171, 1'b0, 1'b1, 1'b0, 8'h3C, "p16_even_perr");
      idle(10);
      send_frame(8'h01, 6'd32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, t0);
      add_pin(t0 + 339, 1'b0, 1'b0, 1'b1, 8'h3C, "p32_stop_err");
      idle(80);
      send_frame(8'hFF, 6'd32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1, t0);
      add_pin(t0 + 339, 1'b1, 1'b0, 1'b0, 8'hFF, "p32_after_serr");
      idle(10);
      for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 6'd16, 1'b0, 1'b0);
      idle(30);
      send_frame(8'h55, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0);
      add_pin(t0 + 155, 1'b1, 1'b0, 1'b0, 8'h55, "after_glitch");
      idle(10);
      send_frame(8'h12, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, t1);
      send_frame(8'h34, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, t2);
      add_pin(t1 + 79, 1'b1, 1'b0, 1'b0, 8'h12, "b2b_first");
      add_pin(t1 + 159, 1'b1, 1'b0, 1'b0, 8'h34, "b2b_second");
      idle(10);
      send_frame(8'h77, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 26, t0);
      add_pin(t0 + 27, 1'b0, 1'b0, 1'b0, 8'h00, "mid_frame_reset");
      idle(10);
      send_frame(8'h9E, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0);
      add_pin(t0 + 79, 1'b1, 1'b0, 1'b0, 8'h9E, "after_reset");
      idle(10);

      // ---------------- randomized stimulus ----------------
      for (int f = 0; f < 40; f++) begin
         case ($urandom_range(0, 6))
            0, 1: rp = 6'd8;
            2, 3: rp = 6'd16;
            4:    rp = 6'd32;
            5:    rp = 6'd12;
            default: rp = 6'($urandom);
         endcase
         if ($urandom_range(0, 9) == 0) begin
            for (int i = 0; i < int'($urandom_range(1, 4)); i++) push(1'b0, 1'b0, rp, 1'b0, 1'b0);
            idle(40);
         end
         send_frame(8'($urandom), rp, 1'($urandom), 1'($urandom),
                    1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) != 0), 1'b1,
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 200)) : -1, t0);
         idle(int'($urandom_range(0, 40)));
      end
      idle(400);

      // ---------------- play and check ----------------
      busy = 1'b0; t0m = 0; pm = 8; pem = 1'b0; ptm = 1'b0;
      exp_dv = 1'b0; exp_pe = 1'b0; exp_se = 1'b0; exp_pd = '0;

      for (int c = 0; c < stim_q.size(); c++) begin
         @(posedge clk);
         #1;
         chk("data_valid", c, 32'(data_valid), 32'(exp_dv));
         chk("par_err",    c, 32'(par_err),    32'(exp_pe));
         chk("stop_err",   c, 32'(stop_err),   32'(exp_se));
         chk("p_data",     c, 32'(p_data),     32'(exp_pd));
         foreach (pin_q[i]) begin
            if (pin_q[i].cyc == c) begin
               chk({pin_q[i].nm, "_dv"},       c, 32'(data_valid), 32'(pin_q[i].dv));
               chk({pin_q[i].nm, "_perr"},     c, 32'(par_err),    32'(pin_q[i].pe));
               chk({pin_q[i].nm, "_serr"},     c, 32'(stop_err),   32'(pin_q[i].se));
               chk({pin_q[i].nm, "_pdata"},    c, 32'(p_data),     32'(pin_q[i].pd));
               chk({pin_q[i].nm, "_model_dv"}, c, 32'(exp_dv),     32'(pin_q[i].dv));
               chk({pin_q[i].nm, "_model_pd"}, c, 32'(exp_pd),     32'(pin_q[i].pd));
            end
         end

         s = stim_q[c];
         rst = s.rst; rx_in = s.rx; prescale = s.pre; par_en = s.pe; par_typ = s.pt;
         line_h[c] = s.rx;

         // Model: expected outputs for cycle c+1.
         nd = 1'b0; np = 1'b0; ns = 1'b0; npd = exp_pd;
         if (s.rst) begin
            busy = 1'b0;
            npd  = '0;
         end else if (!busy) begin
            if (!s.rx) begin
               busy = 1'b1; t0m = c; pm = peff(s.pre); pem = s.pe; ptm = s.pt;
            end
         end else begin
            k  = c - t0m;
            nb = 1 + int'(W) + int'(pem);
            if (k == pm - 1 && maj(t0m, pm, 0)) begin
               busy = 1'b0;
            end else if (k == nb * pm + pm / 2 + 2) begin
               for (int i = 0; i < int'(W); i++) dbyte[i] = maj(t0m, pm, i + 1);
               perr = pem && (maj(t0m, pm, int'(W) + 1) != ((^dbyte) ^ ptm));
               stp  = maj(t0m, pm, nb);
               if (!perr && stp) begin
                  nd = 1'b1; npd = dbyte;
               end else begin
                  np = perr; ns = !stp;
               end
               busy = 1'b0;
            end
         end
         exp_dv = nd; exp_pe = np; exp_se = ns; exp_pd = npd;
      end

      n = tests;
      $display("[TB] %0d tests run, %0d failed", n, fails);
      $finish;
   end

endmodule
